// File: rtl/apb_req_arbiter.sv
// Purpose : round-robin arbiter that lets two clients share one APB slave, running SETUP/ACCESS
// Latency : accept at N -> SETUP N+1 -> ACCESS N+2 (+1 per PREADY-low cycle) -> rsp_valid pulse N+3
// Backpr. : req_ready only in IDLE for the winner; responses are unthrottled one-cycle pulses
//
// Ports:
//   PCLK / PRESET          clock, asynchronous active-low reset
//   req_valid/ready/write  per-requester command handshake (bit i = requester i)
//   req_addr / req_wdata   packed per-requester command fields (slice i = requester i)
//   rsp_valid              per-requester one-cycle response pulse
//   rsp_rdata / rsp_err    shared response payload, qualified by rsp_valid, held between pulses
//   PADDR..PWDATA          APB master outputs; PREADY/PRDATA/PSLVERR APB slave inputs
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES
// PREADY-low cycles with rsp_err=1 and rsp_rdata=0.
module apb_req_arbiter #(
  parameter int ADDRWIDTH      = 8,
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_write,
  input  logic [2*ADDRWIDTH-1:0] req_addr,
  input  logic [2*DATAWIDTH-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [DATAWIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDRWIDTH-1:0]   PADDR,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [DATAWIDTH-1:0]   PWDATA,
  input  logic                   PREADY,
  input  logic [DATAWIDTH-1:0]   PRDATA,
  input  logic                   PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;       // preferred requester
  logic                   gnt_q, gnt_d;     // owner of the in-flight command
  logic                   write_q, write_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   win;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]       tmo_q, tmo_d;
`endif

  // Preferred requester wins whenever it is asking; otherwise the other one.
  assign win = req_valid[rr_q] ? rr_q : ~rr_q;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 2'b00;
`ifdef APB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // win always has its valid set whenever any valid is set, so the
        // handshake completes in the same cycle ready is raised.
        if (|req_valid) begin
          req_ready = win ? 2'b10 : 2'b01;
          write_d   = req_write[win];
          addr_d    = win ? req_addr[2*ADDRWIDTH-1:ADDRWIDTH] : req_addr[ADDRWIDTH-1:0];
          wdata_d   = win ? req_wdata[2*DATAWIDTH-1:DATAWIDTH] : req_wdata[DATAWIDTH-1:0];
          gnt_d     = win;
          rr_d      = ~win;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
`ifdef APB_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          rdata_d = write_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          state_d = ST_RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_valid = (state_q == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
